// File: rtl/io_mem_responder.sv
// Memory-side responder for the CPU byte bus: synchronous byte RAM below IO_BASE,
// buffered TX byte port and status register above it, with a halt request while TX is full.
module io_mem_responder #(
    parameter int unsigned       ADDR_W     = 17,
    parameter int unsigned       RAM_AW     = 16,
    parameter logic [ADDR_W-1:0] IO_BASE    = 17'h10000,
    parameter int unsigned       FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_a_i,
    input  logic              mem_wr_i,
    input  logic [7:0]        mem_dout_i,
    output logic [7:0]        mem_din_o,
    output logic [1:0]        halt_req_o,
    output logic [7:0]        io_tx_data_o,
    output logic              io_tx_valid_o,
    input  logic              io_tx_ready_i
);

    localparam int unsigned       PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned       CntW       = PtrW + 1;
    localparam logic [ADDR_W-1:0] StatusAddr = IO_BASE + ADDR_W'(4);
    localparam logic [CntW-1:0]   FullCnt    = CntW'(FIFO_DEPTH);

    logic [7:0]      ram_q [2**RAM_AW];
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      mem_din_q, mem_din_d;

    logic              is_ram, is_tx, is_st;
    logic              full, empty, push, pop;
    logic [RAM_AW-1:0] ram_idx;

    always_comb begin
        ram_idx = mem_a_i[RAM_AW-1:0];
        is_ram  = (mem_a_i < IO_BASE);
        is_tx   = (mem_a_i == IO_BASE);
        is_st   = (mem_a_i == StatusAddr);
        full    = (count_q == FullCnt);
        empty   = (count_q == '0);
        // Full comes from the registered count only, so a same-cycle pop never admits a push.
        push    = is_tx & mem_wr_i & ~full;
        pop     = ~empty & io_tx_ready_i;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        // Read-first: a write cycle returns the byte held before the write.
        mem_din_d = 8'h00;
        if (is_ram) begin
            mem_din_d = ram_q[ram_idx];
        end else if (is_st) begin
            mem_din_d = {6'b0, empty, full};
        end
    end

    always_ff @(posedge clk) begin
        if (is_ram && mem_wr_i) begin
            ram_q[ram_idx] <= mem_dout_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            mem_din_q <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            mem_din_q <= mem_din_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_dout_i;
            end
        end
    end

    assign mem_din_o     = mem_din_q;
    assign halt_req_o    = (is_tx && mem_wr_i && full) ? 2'b01 : 2'b00;
    assign io_tx_valid_o = ~empty;
    assign io_tx_data_o  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_io_mem_responder.sv
// Scoreboard bench for io_mem_responder: a small bus/FIFO model predicts read data,
// halt and the TX byte stream; expectations are queued at drive time and popped on output.
module tb_io_mem_responder;

    localparam logic [16:0] IoBase = 17'h10000;
    localparam logic [16:0] StAddr = 17'h10004;
    localparam logic [16:0] UnAddr = 17'h10008;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [16:0] mem_a_i = '0;
    logic        mem_wr_i = 1'b0;
    logic [7:0]  mem_dout_i = '0;
    logic [7:0]  mem_din_o;
    logic [1:0]  halt_req_o;
    logic [7:0]  io_tx_data_o;
    logic        io_tx_valid_o;
    logic        io_tx_ready_i = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] ram_m [int];
    logic [7:0] tx_q [$];
    logic [7:0] rd_q [$];
    int         mcount = 0;

    always #5 clk = ~clk;

    io_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .mem_a_i      (mem_a_i),
        .mem_wr_i     (mem_wr_i),
        .mem_dout_i   (mem_dout_i),
        .mem_din_o    (mem_din_o),
        .halt_req_o   (halt_req_o),
        .io_tx_data_o (io_tx_data_o),
        .io_tx_valid_o(io_tx_valid_o),
        .io_tx_ready_i(io_tx_ready_i)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle, entered and left at posedge+1; returns whether the model accepted a push.
    task automatic bus_cycle(input logic [16:0] a, input logic wr, input logic [7:0] d,
                             input logic rdy, output logic pushed);
        logic full_m, push_m, pop_m;
        logic [7:0] exp_rd;
        mem_a_i       = a;
        mem_wr_i      = wr;
        mem_dout_i    = d;
        io_tx_ready_i = rdy;
        full_m = (mcount == 8);
        push_m = (a == IoBase) && wr && !full_m;
        pop_m  = (mcount != 0) && rdy;
        if (!wr) begin
            if (a < IoBase)       exp_rd = ram_m[int'(a)];
            else if (a == StAddr) exp_rd = {6'b0, mcount == 0, full_m};
            else                  exp_rd = 8'h00;
            rd_q.push_back(exp_rd);
        end
        @(negedge clk);
        check("halt", {6'b0, halt_req_o}, (a == IoBase && wr && full_m) ? 8'h01 : 8'h00);
        check("valid", {7'b0, io_tx_valid_o}, {7'b0, mcount != 0});
        if (pop_m) check("txdata", io_tx_data_o, tx_q.pop_front());
        @(posedge clk);
        #1;
        if (wr && a < IoBase) ram_m[int'(a)] = d;
        if (push_m) tx_q.push_back(d);
        mcount = mcount + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
        if (!wr) check("rdata", mem_din_o, rd_q.pop_front());
        pushed = push_m;
    endtask

    task automatic rd(input logic [16:0] a);
        logic p;
        bus_cycle(a, 1'b0, 8'h00, 1'b0, p);
    endtask

    task automatic wr_ram(input logic [16:0] a, input logic [7:0] d);
        logic p;
        bus_cycle(a, 1'b1, d, 1'b0, p);
    endtask

    // CPU-style write to TXDATA: hold the strobe until the model says it landed.
    task automatic tx_write(input logic [7:0] d, input logic rdy);
        logic p;
        p = 1'b0;
        for (int k = 0; k < 50 && !p; k++) bus_cycle(IoBase, 1'b1, d, rdy, p);
        if (!p) check("tx_write_timeout", 8'h00, 8'h01);
    endtask

    task automatic drain();
        logic p;
        for (int k = 0; k < 20 && mcount != 0; k++) bus_cycle(17'h00000, 1'b0, 8'h00, 1'b1, p);
        if (mcount != 0) check("drain_timeout", 8'h00, 8'h01);
        void'(rd_q.pop_back());
    endtask

    initial begin
        logic p;
        logic rdy;
        #1;
        check("rst_din", mem_din_o, 8'h00);
        check("rst_halt", {6'b0, halt_req_o}, 8'h00);
        check("rst_valid", {7'b0, io_tx_valid_o}, 8'h00);
        check("rst_txdata", io_tx_data_o, 8'h00);
        #20;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Preload, then RAM write followed by read of the same address.
        wr_ram(17'h00000, 8'h11);
        wr_ram(17'h00124, 8'h3C);
        wr_ram(17'h00123, 8'hA5);
        rd(17'h00123);
        rd(17'h00124);
        rd(17'h00000);

        // 'H','i' with an always-ready sink.
        tx_write(8'h48, 1'b1);
        tx_write(8'h69, 1'b1);
        bus_cycle(17'h00000, 1'b0, 8'h00, 1'b1, p);
        bus_cycle(17'h00000, 1'b0, 8'h00, 1'b1, p);
        check("hi_empty", {7'b0, io_tx_valid_o}, 8'h00);

        // Fill to full, stall a 9th write, then one ready cycle releases it.
        for (int i = 0; i < 8; i++) tx_write(8'(i), 1'b0);
        rd(StAddr);
        bus_cycle(IoBase, 1'b1, 8'h08, 1'b0, p);
        bus_cycle(IoBase, 1'b1, 8'h08, 1'b0, p);
        bus_cycle(IoBase, 1'b1, 8'h08, 1'b1, p);
        bus_cycle(IoBase, 1'b1, 8'h08, 1'b0, p);
        check("stall_pushed", {7'b0, p}, 8'h01);
        rd(StAddr);
        drain();

        // Wrap-around with ready toggling each cycle.
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            p = 1'b0;
            for (int k = 0; k < 50 && !p; k++) begin
                bus_cycle(IoBase, 1'b1, 8'(i), rdy, p);
                rdy = ~rdy;
            end
        end
        drain();
        check("wrap_left", 8'(tx_q.size()), 8'h00);

        // Async reset while stalled with 8 bytes queued.
        for (int i = 0; i < 8; i++) tx_write(8'(8'h80 + i), 1'b0);
        bus_cycle(IoBase, 1'b1, 8'hEE, 1'b0, p);
        rd(17'h00123);
        bus_cycle(IoBase, 1'b1, 8'hEE, 1'b0, p);
        #3;
        rst = 1'b0;
        #1;
        check("arst_din", mem_din_o, 8'h00);
        check("arst_halt", {6'b0, halt_req_o}, 8'h00);
        check("arst_valid", {7'b0, io_tx_valid_o}, 8'h00);
        check("arst_txdata", io_tx_data_o, 8'h00);
        mcount = 0;
        tx_q.delete();
        mem_wr_i = 1'b0;
        mem_a_i  = 17'h00000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd(StAddr);
        rd(17'h00123);
        rd(17'h00124);

        // Unmapped and TXDATA reads, dropped unmapped write.
        wr_ram(17'h00050, 8'h77);
        rd(17'h00050);
        rd(UnAddr);
        rd(17'h00050);
        rd(IoBase);
        bus_cycle(UnAddr, 1'b1, 8'h5A, 1'b1, p);
        rd(StAddr);
        check("unmapped_valid", {7'b0, io_tx_valid_o}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
